// File: rtl/fifo_pkg.sv
// Shared constants and parameter checks for the programmable-flag FIFO.
package fifo_pkg;

   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_AFULL  = 2;
   localparam int ST_AEMPTY = 3;
   localparam int ST_OVF    = 4;
   localparam int ST_UNF    = 5;
   localparam int ST_W      = 6;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int depth,
                                    input int af,
                                    input int ae);
      return is_pow2(depth)
         && (af >= 1) && (af <= depth)
         && (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter: low bits index storage, top bit tells
// full from empty when the indices match.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int adr_width = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   output logic [adr_width:0]   ptr
);

   always_ff @(posedge clk) begin
      if (!rst)
         ptr <= '0;
      else if (en)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/fifo_prog_flags.sv
// Single-clock FIFO with fill level, programmable almost flags,
// sticky error flags and standard or first-word-fall-through reads.
module fifo_prog_flags
   import fifo_pkg::*;
#(
   parameter bit fwft_enable = 1'b1,
   parameter int width       = 16,
   parameter int depth       = 8,
   parameter int adr_width   = $clog2(depth),
   parameter int af_thresh   = 6,
   parameter int ae_thresh   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [width-1:0]     data_in,
   input  logic                 we,
   input  logic                 re,
   input  logic                 clr_err,
   output logic [width-1:0]     data_out,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [adr_width:0]   level,
   output logic                 overflow,
   output logic                 underflow
);

   if (!params_ok(depth, af_thresh, ae_thresh)) begin : g_bad_params
      $error("fifo_prog_flags: illegal depth or threshold");
   end

   localparam logic [adr_width:0] AF_LVL = (adr_width + 1)'(af_thresh);
   localparam logic [adr_width:0] AE_LVL = (adr_width + 1)'(ae_thresh);

   logic [adr_width:0]   w_ptr;
   logic [adr_width:0]   r_ptr;
   logic [adr_width-1:0] w_idx;
   logic [adr_width-1:0] r_idx;
   logic                 rd_ok;
   logic                 wr_ok;
   logic                 ovf_q;
   logic                 unf_q;
   logic [ST_W-1:0]      st;
   logic [width-1:0]     mem [depth];

   assign w_idx = w_ptr[adr_width-1:0];
   assign r_idx = r_ptr[adr_width-1:0];
   assign level = w_ptr - r_ptr;

   assign st[ST_EMPTY]  = (w_ptr == r_ptr);
   assign st[ST_FULL]   = (w_idx == r_idx)
                        && (w_ptr[adr_width] != r_ptr[adr_width]);
   assign st[ST_AFULL]  = (level >= AF_LVL);
   assign st[ST_AEMPTY] = (level <= AE_LVL);
   assign st[ST_OVF]    = ovf_q;
   assign st[ST_UNF]    = unf_q;

   assign fifo_full    = st[ST_FULL];
   assign fifo_empty   = st[ST_EMPTY];
   assign almost_full  = st[ST_AFULL];
   assign almost_empty = st[ST_AEMPTY];
   assign overflow     = st[ST_OVF];
   assign underflow    = st[ST_UNF];

   // A read at full frees the slot the same-cycle write lands in.
   assign rd_ok = rst & re & ~st[ST_EMPTY];
   assign wr_ok = rst & we & (~st[ST_FULL] | rd_ok);

   fifo_ptr #(.adr_width(adr_width)) u_wptr (
      .clk (clk),
      .rst (rst),
      .en  (wr_ok),
      .ptr (w_ptr)
   );

   fifo_ptr #(.adr_width(adr_width)) u_rptr (
      .clk (clk),
      .rst (rst),
      .en  (rd_ok),
      .ptr (r_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[w_idx] <= data_in;
   end

   // A new error in the clear cycle wins over clr_err.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (clr_err) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end
         if (we & ~wr_ok)
            ovf_q <= 1'b1;
         if (re & ~rd_ok)
            unf_q <= 1'b1;
      end
   end

   if (fwft_enable) begin : g_fwft
      assign data_out = mem[r_idx];
   end else begin : g_std
      always_ff @(posedge clk) begin
         if (!rst)
            data_out <= '0;
         else if (rd_ok)
            data_out <= mem[r_idx];
      end
   end

endmodule

// File: tb/tb_fifo_prog_flags.sv
// Drives a standard-mode and an FWFT instance with identical stimulus
// and compares both against a queue-based reference model.
module tb_fifo_prog_flags;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n, we, re, clr;
   logic [W-1:0]  din;

   logic [W-1:0]  s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [AW:0]   s_lvl, f_lvl;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  q[$];
   logic [W-1:0]  m_std;
   logic          m_ovf, m_unf;

   always #5 clk = ~clk;

   fifo_prog_flags #(.fwft_enable(1'b0)) u_std (
      .clk(clk), .rst(rst_n), .data_in(din), .we(we), .re(re),
      .clr_err(clr), .data_out(s_dout), .fifo_full(s_full),
      .fifo_empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .level(s_lvl), .overflow(s_ovf),
      .underflow(s_unf)
   );

   fifo_prog_flags #(.fwft_enable(1'b1)) u_fw (
      .clk(clk), .rst(rst_n), .data_in(din), .we(we), .re(re),
      .clr_err(clr), .data_out(f_dout), .fifo_full(f_full),
      .fifo_empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .level(f_lvl), .overflow(f_ovf),
      .underflow(f_unf)
   );

   typedef struct {
      logic         rst_n, we, re, clr;
      logic [W-1:0] din;
      int           lvl;
      logic         ovf, unf, full, empty;
      logic [W-1:0] dout;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic w, logic rd, logic c,
                               logic [W-1:0] d, int l, logic o,
                               logic u, logic fu, logic em,
                               logic [W-1:0] dq);
      vec_t v;
      v.rst_n = r; v.we = w; v.re = rd; v.clr = c; v.din = d;
      v.lvl = l; v.ovf = o; v.unf = u; v.full = fu; v.empty = em;
      v.dout = dq;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference behaviour: a bounded queue with sticky error bits.
   task automatic model_tick(logic r, logic w, logic rd, logic c,
                             logic [W-1:0] d);
      bit do_rd, do_wr;
      if (!r) begin
         q.delete();
         m_std = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
         return;
      end
      do_rd = rd && (q.size() > 0);
      do_wr = w && ((q.size() < D) || do_rd);
      if (do_rd) m_std = q.pop_front();
      if (do_wr) q.push_back(d);
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (w && !do_wr) m_ovf = 1'b1;
      if (rd && !do_rd) m_unf = 1'b1;
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("s_level", 32'(s_lvl), 32'(n));
      chk("f_level", 32'(f_lvl), 32'(n));
      chk("s_full", 32'(s_full), 32'(n == D));
      chk("f_full", 32'(f_full), 32'(n == D));
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("f_empty", 32'(f_empty), 32'(n == 0));
      chk("s_afull", 32'(s_af), 32'(n >= 6));
      chk("f_afull", 32'(f_af), 32'(n >= 6));
      chk("s_aempty", 32'(s_ae), 32'(n <= 1));
      chk("f_aempty", 32'(f_ae), 32'(n <= 1));
      chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
      chk("s_unf", 32'(s_unf), 32'(m_unf));
      chk("f_unf", 32'(f_unf), 32'(m_unf));
      chk("s_dout", 32'(s_dout), 32'(m_std));
      if (n > 0) chk("f_dout", 32'(f_dout), 32'(q[0]));
   endtask

   task automatic cycle(logic r, logic w, logic rd, logic c,
                        logic [W-1:0] d);
      rst_n = r; we = w; re = rd; clr = c; din = d;
      @(posedge clk);
      model_tick(r, w, rd, c, d);
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; din = '0;
      m_std = '0; m_ovf = 1'b0; m_unf = 1'b0;

      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(1, 1, 0, 0, W'(i), i, 0, 0, i == 8, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 16'd9, 8, 1, 0, 1, 0, 0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(1, 0, 1, 0, 0, 8 - i, 1, 0, 0, i == 8,
                          W'(i)));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 16'd8));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'd8));
      tbl.push_back(mk(1, 1, 1, 0, 16'h0055, 1, 0, 1, 0, 0, 16'd8));
      tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0055));

      foreach (tbl[k]) begin
         cycle(tbl[k].rst_n, tbl[k].we, tbl[k].re, tbl[k].clr,
               tbl[k].din);
         chk("tbl_level", 32'(s_lvl), 32'(tbl[k].lvl));
         chk("tbl_ovf", 32'(s_ovf), 32'(tbl[k].ovf));
         chk("tbl_unf", 32'(s_unf), 32'(tbl[k].unf));
         chk("tbl_full", 32'(s_full), 32'(tbl[k].full));
         chk("tbl_empty", 32'(s_empty), 32'(tbl[k].empty));
         chk("tbl_dout", 32'(s_dout), 32'(tbl[k].dout));
      end

      // FWFT: write shows up without a read request
      cycle(1, 1, 0, 0, 16'hA5A5);
      chk("fwft_first", 32'(f_dout), 32'h0000A5A5);
      chk("fwft_nonempty", 32'(f_empty), 32'd0);
      cycle(1, 0, 1, 0, 0);
      chk("fwft_drained", 32'(f_empty), 32'd1);

      // full plus simultaneous write/read
      for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, W'(16'h100 + i));
      cycle(1, 1, 1, 0, 16'h00FF);
      chk("full_rw_head", 32'(s_dout), 32'h100);
      chk("full_rw_level", 32'(s_lvl), 32'd8);
      chk("full_rw_ovf", 32'(s_ovf), 32'd0);
      for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
      chk("full_rw_last", 32'(s_dout), 32'h00FF);

      // wrap-around with interleaved pairs
      for (int i = 0; i < 20; i++) begin
         cycle(1, 1, 0, 0, W'(16'h200 + i));
         chk("wrap_lvl_le2", 32'(s_lvl <= 2), 32'd1);
         cycle(1, 0, 1, 0, 0);
         chk("wrap_data", 32'(s_dout), 32'(16'h200 + i));
      end

      // randomized phases alternating fill- and drain-biased traffic
      for (int n = 0; n < 400; n++) begin
         bit fill;
         fill = ((n / 40) % 2) == 0;
         cycle(($urandom_range(99) != 0),
               ($urandom_range(99) < (fill ? 70 : 30)),
               ($urandom_range(99) < (fill ? 30 : 70)),
               ($urandom_range(15) == 0),
               W'($urandom));
      end

      // reset in the middle of a stream
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, W'(16'h300 + i));
      chk("mid_level5", 32'(s_lvl), 32'd5);
      chk("mid_unf_set", 32'(s_unf), 32'd1);
      cycle(0, 1, 1, 0, 16'hDEAD);
      chk("mid_rst_level", 32'(s_lvl), 32'd0);
      chk("mid_rst_empty", 32'(f_empty), 32'd1);
      chk("mid_rst_unf", 32'(s_unf), 32'd0);
      cycle(1, 1, 0, 0, 16'h1234);
      chk("post_rst_fwft", 32'(f_dout), 32'h1234);
      cycle(1, 0, 1, 0, 0);
      chk("post_rst_std", 32'(s_dout), 32'h1234);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_prog_flags.md
Name: fifo_prog_flags

Overview:
Parametrised synchronous FIFO; successor to the current 8-deep FIFO block.
- Single-clock storage with selectable standard or first-word-fall-through (FWFT) read mode.
- Adds a fill-level output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and legal simultaneous read+write at full.
- Sits between producer/consumer datapaths in the same clock domain.

Parameters:
- fwft_enable, 1, 1 = FWFT head-of-queue on data_out; 0 = registered read, data one cycle after accepted re.
- width, 16, data bits per entry.
- depth, 8, number of entries; must be a power of two and >= 2.
- adr_width, $clog2(depth), storage address bits; pointers are adr_width+1 bits.
- af_thresh, 6, almost_full asserts when level >= af_thresh; range 1..depth.
- ae_thresh, 1, almost_empty asserts when level <= ae_thresh; range 0..depth-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- data_in  in  width  write data.
- we  in  1  write request.
- re  in  1  read request.
- clr_err  in  1  synchronous clear of the sticky error flags.
- data_out  out  width  read data.
- fifo_full  out  1  level == depth.
- fifo_empty  out  1  level == 0.
- almost_full  out  1  level >= af_thresh.
- almost_empty  out  1  level <= ae_thresh.
- level  out  adr_width+1  current entry count, 0..depth.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst==0 at a clk edge):
  - w_ptr = r_ptr = 0, level = 0, fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0; data_out = 0 in standard mode.
  - we/re are ignored in the reset cycle. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded; outputs take their reset values at that edge.
- Pointers are adr_width+1 bits with a wrap bit.
  - level = w_ptr - r_ptr, modulo 2^(adr_width+1).
  - Empty when the pointers are equal; full when the index bits are equal and the wrap bits differ.
- rd_ok = re & ~fifo_empty.
- wr_ok = we & (~fifo_full | rd_ok).
- Accepted write: mem[w_ptr index] <= data_in; w_ptr increments by 1 and wraps naturally.
- Accepted read: r_ptr increments.
- Simultaneous wr_ok and rd_ok: level unchanged.
  - At full, the read returns the old head (read-before-write); the new word lands in the freed slot.
- we & re while empty: write accepted, read rejected, underflow set; level becomes 1.
- Standard mode: on rd_ok, data_out <= mem[r_ptr index] at that edge, so data appears one cycle after re. Otherwise data_out holds.
- FWFT mode: data_out = mem[r_ptr index] combinationally; valid whenever fifo_empty == 0.
  - A write into an empty FIFO is visible on data_out the cycle after the write edge.
  - data_out is don't-care while empty.
- Flags are derived from registered pointers and update on the edge following the causing request.
- overflow sets on we & ~wr_ok; underflow sets on re & ~rd_ok.
  - Both hold until clr_err == 1 or reset.
  - clr_err and a new error in the same cycle leave the flag set.
- Rejected requests never modify pointers or memory.

Decomposition:
- Shared package fifo_pkg:
  - Status-bit index constants for full, empty, almost_full, almost_empty, overflow, underflow.
  - Parameter legality checks: power-of-two depth, threshold ranges.
- One sub-module, fifo_ptr: an (adr_width+1)-bit wrap-bit pointer counter with enable and synchronous active-low reset, instantiated for the write and read pointers.
- The storage array and flag logic live inline in fifo_prog_flags.

Test Plan:
1. Defaults, standard mode: reset, write 8 words 0x0001..0x0008 → fifo_full=1, level=8, almost_full=1 from level 6. A 9th we sets overflow=1 and level stays 8. Read 8 → data_out 0x0001..0x0008, each one cycle after re; fifo_empty=1.
2. FWFT: write 0xA5A5 into an empty FIFO → next cycle fifo_empty=0 and data_out=0xA5A5 with no re. re pulse → fifo_empty=1, level=0.
3. Full plus simultaneous we/re with data_in=0x00FF → read returns the old head, level stays 8, overflow stays 0. Draining returns 0x00FF last.
4. re on empty → underflow=1, level=0. clr_err=1 for one cycle → underflow=0. Simultaneous we/re on empty → level=1, underflow=1.
5. Wrap-around: 20 interleaved write/read pairs with incrementing data → in-order data, level never exceeds 2, pointers wrap with no flag glitch. almost_empty=1 whenever level<=1.
6. Reset mid-stream at level=5 → next cycle level=0, fifo_empty=1, errors cleared. A subsequent write/read of 0x1234 returns 0x1234.
